fmul_issue: RTL and testbench
=============================

FMUL_ISSUE -- requirements
Module: fmul_issue

Interface
REQ-001 SHALL have parameter NSTAGE, default 4, fixed fmul latency in cycles from fmul_en cycle to valid fmul_y.
REQ-002 SHALL have parameter DEPTH, default 8, result FIFO entries; power of two, >= 2.
REQ-003 SHALL have parameter TAGW, default 4, request tag width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset; ports clk and rstn.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 flush  input  1  synchronous discard of all in-flight and queued results.
REQ-008 req_valid  input  1  operand pair offered.
REQ-009 req_x1, req_x2  input  32 each  IEEE-754 single operands.
REQ-010 req_tag  input  TAGW  caller tag returned with the result.
REQ-011 req_ready  output  1  request accepted when req_valid&req_ready at clock edge.
REQ-012 fmul_en, fmul_x1, fmul_x2  output  1/32/32  registered drive to downstream fmul en/x1/x2.
REQ-013 fmul_y  input  32  fmul product.
REQ-014 res_valid, res_y, res_tag  output  1/32/TAGW  head of result FIFO.
REQ-015 res_ready  input  1  consumer pops head when res_valid&res_ready.
REQ-016 inflight  output  $clog2(NSTAGE+2)  count of issued, not yet captured operations.
REQ-017 res_cnt  output  32  total results captured since reset/flush, wraps modulo 2^32.

Function
REQ-018 Acceptance in cycle a SHALL drive fmul_en=1 with fmul_x1/x2=req_x1/x2 in cycle a+1; otherwise fmul_en=0 and fmul_x1/x2 hold.
REQ-019 A tag/valid shift pipeline of NSTAGE+1 stages SHALL track each issued op; fmul_y SHALL be sampled at end of cycle a+1+NSTAGE and pushed with its tag.
REQ-020 res_valid for that op SHALL rise no earlier than cycle a+2+NSTAGE (a+6 at default); no bypass path.
REQ-021 req_ready SHALL be (fifo_count + inflight) < DEPTH, from registered state only, no combinational path from req_valid or res_ready.
REQ-022 Throughput SHALL be one accept per cycle while credit remains; results SHALL leave in issue order.
REQ-023 Simultaneous capture and pop SHALL keep fifo_count unchanged, including when full; push to a full FIFO SHALL be impossible by REQ-021.
REQ-024 Pop on empty FIFO SHALL be ignored; res_y/res_tag SHALL hold while res_valid and !res_ready.
REQ-025 flush=1 SHALL, at the edge, clear all pipeline valids, empty the FIFO, zero res_cnt; req_ready SHALL be 0 during a flush cycle and a request offered then is not accepted.
REQ-026 inflight SHALL increment on accept, decrement on capture, unchanged when both occur in the same cycle.
REQ-027 FIFO pointers SHALL wrap modulo DEPTH; res_cnt SHALL increment on each capture.

Reset
REQ-028 rstn=0 SHALL asynchronously clear pipeline valids, FIFO pointers, inflight, res_cnt, fmul_en, res_valid; fmul_x1/x2, res_y, res_tag reset to 0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight ops; no result for them SHALL appear after release.
REQ-030 req_ready SHALL be 1 in the first cycle after rstn deasserts (flush=0).

Structure
REQ-031 Shared package fpu_pkg SHALL hold FMUL_NSTAGE, TAGW default, and typedef fmul_res_t {tag, y}.
REQ-032 Result storage SHALL be one sub-module res_fifo (synchronous, DEPTH x fmul_res_t, count output, sync clear).
REQ-033 Bench SHALL drive fmul_y from a behavioural NSTAGE-cycle multiplier model or the real fmul.

Verification
REQ-034 Accept 0x40000000 x 0x40400000 tag 3 in cycle 10, res_ready=1 -> fmul_en high cycle 11, res_valid cycle 16, res_y=0x40C00000, res_tag=3.
REQ-035 res_ready=0, req_valid=1 continuously -> exactly 8 accepts (tags 0..7), req_ready=0 thereafter; one pop -> exactly one further accept.
REQ-036 Back-to-back 16 requests tags 0..15, res_ready=1 -> 16 results in order, one per cycle, res_cnt=16, inflight returns to 0.
REQ-037 flush with 3 in flight and 2 queued -> res_valid=0 next cycle, inflight=0, res_cnt=0, no late results within 2*NSTAGE cycles.
REQ-038 rstn low mid-stream for one cycle -> all outputs at reset values asynchronously; no stale results after release; req_ready=1.
REQ-039 Simultaneous capture and pop at fifo_count=DEPTH -> count stays DEPTH, order preserved.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg -- definitions shared by the fmul issue block and its result FIFO.
//   FMUL_NSTAGE : pipeline depth of the downstream single-precision multiplier
//   FMUL_TAGW   : default width of the caller tag carried alongside each op
//   fmul_res_t  : one queued result, {tag, product}
package fpu_pkg;

  localparam int FMUL_NSTAGE = 4;
  localparam int FMUL_TAGW   = 4;

  typedef struct packed {
    logic [FMUL_TAGW-1:0] tag;
    logic [31:0]          y;
  } fmul_res_t;

endpackage

// File: rtl/res_fifo.sv
// res_fifo -- synchronous result queue, DEPTH entries of type T.
//   clk, rstn : clock, asynchronous active-low reset (pointers and count)
//   clr       : synchronous clear, empties the queue
//   push, din : enqueue din at the tail
//   pop       : dequeue the head; ignored while empty
//   dout      : head entry, forced to zero while empty
//   valid     : queue non-empty
//   count     : number of occupied entries
module res_fifo
  import fpu_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter type T     = fmul_res_t
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  input  logic                       push,
  input  T                           din,
  input  logic                       pop,
  output T                           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_ok;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; an empty queue masks whatever it holds
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_ptr_q] <= din;
  end

  assign valid = (count_q != '0);
  assign dout  = valid ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;

endmodule

// File: rtl/fmul_issue.sv
// fmul_issue -- issues operand pairs to a fixed-latency multiplier and
// collects the products, in issue order, into a credit-protected FIFO.
//   clk, rstn                  : clock, asynchronous active-low reset
//   flush                      : synchronous discard of in-flight and queued results
//   req_valid/ready, x1/x2/tag : request handshake, operands, caller tag
//   fmul_en, fmul_x1/x2        : registered drive to the multiplier
//   fmul_y                     : multiplier product, valid NSTAGE cycles after fmul_en
//   res_valid/ready, y/tag     : head of the result FIFO
//   inflight                   : ops issued and not yet captured
//   res_cnt                    : results captured since reset or flush
module fmul_issue
  import fpu_pkg::*;
#(
  parameter int NSTAGE = FMUL_NSTAGE,
  parameter int DEPTH  = 8,
  parameter int TAGW   = FMUL_TAGW
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush,
  input  logic                        req_valid,
  input  logic [31:0]                 req_x1,
  input  logic [31:0]                 req_x2,
  input  logic [TAGW-1:0]             req_tag,
  output logic                        req_ready,
  output logic                        fmul_en,
  output logic [31:0]                 fmul_x1,
  output logic [31:0]                 fmul_x2,
  input  logic [31:0]                 fmul_y,
  output logic                        res_valid,
  output logic [31:0]                 res_y,
  output logic [TAGW-1:0]             res_tag,
  input  logic                        res_ready,
  output logic [$clog2(NSTAGE+2)-1:0] inflight,
  output logic [31:0]                 res_cnt
);

  localparam int IW = $clog2(NSTAGE+2);
  localparam int CW = $clog2(DEPTH+1);

  // Local result type so a non-default TAGW still fits the queue
  typedef struct packed {
    logic [TAGW-1:0] tag;
    logic [31:0]     y;
  } res_t;

  logic            accept, capture;
  logic [NSTAGE:0] vld_q, vld_d;
  logic [TAGW-1:0] tag_q [NSTAGE+1];
  logic [TAGW-1:0] tag_d [NSTAGE+1];
  logic            fmul_en_q, fmul_en_d;
  logic [31:0]     fmul_x1_q, fmul_x1_d;
  logic [31:0]     fmul_x2_q, fmul_x2_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [31:0]     res_cnt_q, res_cnt_d;
  logic [CW-1:0]   fifo_cnt;
  res_t            fifo_din, fifo_dout;

  // Credit covers queued results plus everything still in the pipe, so a
  // capture can never land on a full FIFO. Blocked during flush.
  assign req_ready = !flush && ((32'(fifo_cnt) + 32'(inflight_q)) < 32'(DEPTH));
  assign accept    = req_valid && req_ready;
  assign capture   = vld_q[NSTAGE] && !flush;

  // Stage boundary: issue register and tag/valid pipe (stage 0 matches fmul_en)
  always_comb begin
    vld_d     = flush ? '0 : {vld_q[NSTAGE-1:0], accept};
    tag_d[0]  = req_tag;
    for (int i = 1; i <= NSTAGE; i++) tag_d[i] = tag_q[i-1];
    fmul_en_d = accept;
    fmul_x1_d = accept ? req_x1 : fmul_x1_q;
    fmul_x2_d = accept ? req_x2 : fmul_x2_q;
    inflight_d = inflight_q;
    res_cnt_d  = res_cnt_q;
    if (flush) begin
      inflight_d = '0;
      res_cnt_d  = '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight_d = inflight_q + IW'(1);
        2'b01:   inflight_d = inflight_q - IW'(1);
        default: inflight_d = inflight_q;
      endcase
      if (capture) res_cnt_d = res_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q      <= '0;
      fmul_en_q  <= 1'b0;
      fmul_x1_q  <= '0;
      fmul_x2_q  <= '0;
      inflight_q <= '0;
      res_cnt_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      fmul_en_q  <= fmul_en_d;
      fmul_x1_q  <= fmul_x1_d;
      fmul_x2_q  <= fmul_x2_d;
      inflight_q <= inflight_d;
      res_cnt_q  <= res_cnt_d;
    end
  end

  // Tags are qualified by vld_q, so they need no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i <= NSTAGE; i++) tag_q[i] <= tag_d[i];
  end

  // Stage boundary: product sampled at the last pipe stage into the FIFO
  assign fifo_din.tag = tag_q[NSTAGE];
  assign fifo_din.y   = fmul_y;

  res_fifo #(
    .DEPTH (DEPTH),
    .T     (res_t)
  ) u_res_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (flush),
    .push  (capture),
    .din   (fifo_din),
    .pop   (res_ready),
    .dout  (fifo_dout),
    .valid (res_valid),
    .count (fifo_cnt)
  );

  assign res_y    = fifo_dout.y;
  assign res_tag  = fifo_dout.tag;
  assign fmul_en  = fmul_en_q;
  assign fmul_x1  = fmul_x1_q;
  assign fmul_x2  = fmul_x2_q;
  assign inflight = inflight_q;
  assign res_cnt  = res_cnt_q;

endmodule

// File: tb/tb_fmul_issue.sv
// tb_fmul_issue -- self-checking bench for fmul_issue with a behavioural
// multiplier and a queue-based reference model of the issue/result flow.
module tb_fmul_issue;

  localparam int NSTAGE = 4;
  localparam int DEPTH  = 8;
  localparam int TAGW   = 4;

  logic              clk = 1'b0;
  logic              rstn, flush, req_valid, req_ready, res_ready, res_valid;
  logic [31:0]       req_x1, req_x2, fmul_x1, fmul_x2, fmul_y, res_y, res_cnt;
  logic [TAGW-1:0]   req_tag, res_tag;
  logic              fmul_en;
  logic [2:0]        inflight;

  always #5 clk = ~clk;

  fmul_issue #(.NSTAGE(NSTAGE), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_x1(req_x1), .req_x2(req_x2), .req_tag(req_tag),
    .req_ready(req_ready),
    .fmul_en(fmul_en), .fmul_x1(fmul_x1), .fmul_x2(fmul_x2), .fmul_y(fmul_y),
    .res_valid(res_valid), .res_y(res_y), .res_tag(res_tag), .res_ready(res_ready),
    .inflight(inflight), .res_cnt(res_cnt)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Single-precision helpers: operands are normal with short mantissas so the
  // product is exact and the real-number route gives the true IEEE result.
  function automatic real sp2r(input logic [31:0] f);
    logic [10:0] e;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    return r2sp(sp2r(a) * sp2r(b));
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [10:0] m;
    e = 8'($urandom_range(100, 154));
    m = 11'($urandom);
    return {1'($urandom), e, m, 12'b0};
  endfunction

  // Behavioural multiplier: product appears NSTAGE cycles after fmul_en
  logic [31:0] fpipe [NSTAGE];
  initial for (int i = 0; i < NSTAGE; i++) fpipe[i] = 32'hDEADBEEF;
  always @(posedge clk) begin
    fpipe[0] <= fmul_en ? fmul_ref(fmul_x1, fmul_x2) : 32'hDEADBEEF;
    for (int i = 1; i < NSTAGE; i++) fpipe[i] <= fpipe[i-1];
  end
  assign fmul_y = fpipe[NSTAGE-1];

  // Reference model: ops in flight with edges-to-capture, plus a result queue
  typedef struct { logic [TAGW-1:0] tag; logic [31:0] y; int rem; } op_t;
  typedef struct { logic [TAGW-1:0] tag; logic [31:0] y; } res_t;
  op_t         ops[$];
  res_t        fq[$];
  int unsigned m_cnt = 0;
  bit          m_en = 1'b0;
  bit          m_acc;
  logic [31:0] m_x1 = '0, m_x2 = '0;

  function automatic bit model_ready();
    return !flush && ((fq.size() + ops.size()) < DEPTH);
  endfunction

  initial forever begin
    op_t  o;
    res_t r;
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      ops.delete(); fq.delete(); m_cnt = 0; m_en = 1'b0; m_x1 = '0; m_x2 = '0;
    end else if (flush) begin
      ops.delete(); fq.delete(); m_cnt = 0; m_en = 1'b0;
    end else begin
      m_acc = req_valid && model_ready();
      if (res_ready && fq.size() > 0) r = fq.pop_front();
      for (int i = 0; i < ops.size(); i++) ops[i].rem = ops[i].rem - 1;
      while (ops.size() > 0 && ops[0].rem == 0) begin
        o = ops.pop_front();
        r.tag = o.tag; r.y = o.y;
        fq.push_back(r);
        m_cnt++;
      end
      if (m_acc) begin
        o.tag = req_tag; o.y = fmul_ref(req_x1, req_x2); o.rem = NSTAGE + 1;
        ops.push_back(o);
        m_x1 = req_x1; m_x2 = req_x2;
      end
      m_en = m_acc;
    end
  end

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rstn && chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(model_ready()));
      chk("res_valid", 32'(res_valid), 32'(fq.size() > 0));
      if (fq.size() > 0) begin
        chk("res_y", res_y, fq[0].y);
        chk("res_tag", 32'(res_tag), 32'(fq[0].tag));
      end
      chk("inflight", 32'(inflight), 32'(ops.size()));
      chk("res_cnt", res_cnt, m_cnt);
      chk("fmul_en", 32'(fmul_en), 32'(m_en));
      chk("fmul_x1", fmul_x1, m_x1);
      chk("fmul_x2", fmul_x2, m_x2);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int  acc_cnt, nres, first_c, last_c;
  bit  got;

  initial begin
    rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_x1 = '0; req_x2 = '0;
    req_tag = '0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_res_cnt", res_cnt, 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);

    // Single op: 2.0 x 3.0, tag 3
    step();
    res_ready = 1'b1; req_valid = 1'b1;
    req_x1 = 32'h40000000; req_x2 = 32'h40400000; req_tag = 4'd3;
    step();
    req_valid = 1'b0;
    @(negedge clk);
    chk("one_fmul_en", 32'(fmul_en), 32'd1);
    chk("one_fmul_x1", fmul_x1, 32'h40000000);
    chk("one_fmul_x2", fmul_x2, 32'h40400000);
    for (int k = 2; k <= 7; k++) begin
      @(negedge clk);
      chk("one_res_valid", 32'(res_valid), 32'(k == 6));
      if (k == 6) begin
        chk("one_res_y", res_y, 32'h40C00000);
        chk("one_res_tag", 32'(res_tag), 32'd3);
      end
    end

    // Fill to credit limit with consumer stalled, then release one slot
    step();
    res_ready = 1'b0; req_valid = 1'b1; req_tag = '0;
    req_x1 = rand_op(); req_x2 = rand_op();
    acc_cnt = 0;
    repeat (20) begin
      @(negedge clk); got = req_ready;
      step();
      if (got) begin acc_cnt++; req_tag++; req_x1 = rand_op(); req_x2 = rand_op(); end
    end
    chk("fill_accepts", 32'(acc_cnt), 32'd8);
    @(negedge clk);
    chk("fill_ready", 32'(req_ready), 32'd0);
    step();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    acc_cnt = 0;
    repeat (20) begin
      @(negedge clk); got = req_ready;
      step();
      if (got) begin acc_cnt++; req_tag++; req_x1 = rand_op(); req_x2 = rand_op(); end
    end
    chk("pop_one_accept", 32'(acc_cnt), 32'd1);
    req_valid = 1'b0; res_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("drain_res_cnt", res_cnt, 32'd10);
    chk("drain_inflight", 32'(inflight), 32'd0);

    // Full queue, then stream with simultaneous capture and pop
    step();
    res_ready = 1'b0; req_valid = 1'b1;
    repeat (12) begin req_x1 = rand_op(); req_x2 = rand_op(); req_tag = 4'($urandom); step(); end
    res_ready = 1'b1;
    repeat (30) begin req_x1 = rand_op(); req_x2 = rand_op(); req_tag = 4'($urandom); step(); end
    req_valid = 1'b0;
    repeat (15) step();

    // Flush, then 16 back-to-back ops
    flush = 1'b1;
    step();
    flush = 1'b0; res_ready = 1'b1;
    nres = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 40; c++) begin
      if (c < 16) begin
        req_valid = 1'b1; req_tag = 4'(c); req_x1 = rand_op(); req_x2 = rand_op();
      end else req_valid = 1'b0;
      @(negedge clk);
      if (res_valid) begin
        chk("b2b_tag", 32'(res_tag), 32'(nres));
        nres++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
      step();
    end
    chk("b2b_count", 32'(nres), 32'd16);
    chk("b2b_first", 32'(first_c), 32'd6);
    chk("b2b_span", 32'(last_c - first_c + 1), 32'd16);
    @(negedge clk);
    chk("b2b_res_cnt", res_cnt, 32'd16);
    chk("b2b_inflight", 32'(inflight), 32'd0);

    // Flush with 3 in flight and 2 queued
    step();
    res_ready = 1'b0;
    repeat (5) begin req_valid = 1'b1; req_x1 = rand_op(); req_x2 = rand_op(); req_tag = 4'($urandom); step(); end
    req_valid = 1'b0;
    step(); step();
    flush = 1'b1; req_valid = 1'b1;
    @(negedge clk);
    chk("pre_flush_inflight", 32'(inflight), 32'd3);
    chk("pre_flush_valid", 32'(res_valid), 32'd1);
    chk("flush_ready", 32'(req_ready), 32'd0);
    step();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_res_valid", 32'(res_valid), 32'd0);
    chk("flush_inflight", 32'(inflight), 32'd0);
    chk("flush_res_cnt", res_cnt, 32'd0);
    repeat (2 * NSTAGE) begin
      step();
      @(negedge clk);
      chk("flush_late_valid", 32'(res_valid), 32'd0);
      chk("flush_late_cnt", res_cnt, 32'd0);
    end

    // Asynchronous reset mid-stream
    step();
    res_ready = 1'b0;
    repeat (7) begin req_valid = 1'b1; req_x1 = rand_op(); req_x2 = rand_op(); req_tag = 4'($urandom); step(); end
    #2 rstn = 1'b0; req_valid = 1'b0;
    #1;
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_fmul_en", 32'(fmul_en), 32'd0);
    chk("arst_inflight", 32'(inflight), 32'd0);
    chk("arst_res_cnt", res_cnt, 32'd0);
    chk("arst_res_y", res_y, 32'd0);
    chk("arst_res_tag", 32'(res_tag), 32'd0);
    chk("arst_fmul_x1", fmul_x1, 32'd0);
    chk("arst_fmul_x2", fmul_x2, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("arst_rel_ready", 32'(req_ready), 32'd1);
    res_ready = 1'b1;
    repeat (2 * NSTAGE + 4) begin
      @(negedge clk);
      chk("arst_stale_valid", 32'(res_valid), 32'd0);
    end

    // Randomized traffic with occasional flush
    step();
    repeat (3000) begin
      req_valid = ($urandom_range(0, 3) != 0);
      res_ready = ($urandom_range(0, 1) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      req_x1 = rand_op(); req_x2 = rand_op(); req_tag = 4'($urandom);
      step();
    end
    req_valid = 1'b0; flush = 1'b0; res_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("end_inflight", 32'(inflight), 32'd0);
    chk("end_res_valid", 32'(res_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
